// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module   : nibble_serial_adder_pkg
// Brief    : Shared nibble width, FSM state codes and sizing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Counter must be at least one bit wide even when a single nibble exists.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_add_4bit.sv
// ============================================================================
// Module   : add_4bit
// Brief    : Purely combinational 4-bit adder with carry in and carry out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_i,
    output logic [3:0] S,
    output logic       C_o
);

    assign {C_o, S} = {1'b0, A} + {1'b0, B} + {4'b0000, C_i};

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : WIDTH-bit adder evaluated one nibble per cycle, LSB first, with
//            valid/ready handshakes on the operand and result sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    generate
        if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_width_err
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [NIB_W-1:0] nib_s;
    logic             nib_co;

    add_4bit u_add_4bit (
        .A   (a_sh_q[NIB_W-1:0]),
        .B   (b_sh_q[NIB_W-1:0]),
        .C_i (carry_q),
        .S   (nib_s),
        .C_o (nib_co)
    );

    // New nibble enters at the top so the first nibble ends up at bit 0.
    generate
        if (NIBBLES == 1) begin : g_sum_single
            assign sum_d = nib_s;
        end else begin : g_sum_multi
            assign sum_d = {nib_s, sum_q[WIDTH-1:NIB_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q     <= op_a;
                        b_sh_q     <= op_b;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_q >> NIB_W;
                    b_sh_q  <= b_sh_q >> NIB_W;
                    sum_q   <= sum_d;
                    carry_q <= nib_co;
                    if (cnt_q == LAST_CNT) begin
                        cnt_q       <= '0;
                        cout_q      <= nib_co;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Self-checking bench for nibble_serial_adder at WIDTH 16, 4 and 32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;
    logic [15:0] sum16;
    logic [3:0]  sum4;
    logic [31:0] sum32;
    logic [2:0]  cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op_a(op_a[15:0]), .op_b(op_b[15:0]), .cin(cin), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum16), .cout(cout[0])
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op_a(op_a[3:0]), .op_b(op_b[3:0]), .cin(cin), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum4), .cout(cout[1])
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum32), .cout(cout[2])
    );

    typedef struct {
        int          dut;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int width_of(input int d);
        return (d == 0) ? 16 : ((d == 1) ? 4 : 32);
    endfunction

    function automatic logic [63:0] got_res(input int d);
        case (d)
            0:       return {47'b0, cout[0], sum16};
            1:       return {59'b0, cout[1], sum4};
            default: return {31'b0, cout[2], sum32};
        endcase
    endfunction

    function automatic logic [63:0] model(input int d, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [63:0] m;
        m = (64'd1 << width_of(d)) - 64'd1;
        return ({32'b0, a} & m) + ({32'b0, b} & m) + {63'b0, c};
    endfunction

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input int gap,
                          output logic [63:0] r, output int lat);
        int w;
        w = 0;
        while (!in_ready[d] && w < 50) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", {63'b0, in_ready[d]}, 64'd1);
        op_a = a;
        op_b = b;
        cin  = c;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        check("in_ready_low_in_run", {63'b0, in_ready[d]}, 64'd0);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            tick();
            lat++;
        end
        r = got_res(d);
        for (int i = 0; i < gap; i++) begin
            tick();
            check("result_held", {62'b0, out_valid[d], in_ready[d]} ^ got_res(d), 64'd2 ^ r);
        end
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check("idle_after_handshake", {62'b0, out_valid[d], in_ready[d]}, 64'd1);
    endtask

    vec_t        vecs[13];
    logic [63:0] r;
    logic [63:0] held;
    int          lat;
    int          seen;

    initial begin
        vecs[0]  = '{0, 32'hFFFF, 32'h0001, 1'b0, 64'h10000, 4};
        vecs[1]  = '{0, 32'h1234, 32'h4321, 1'b1, 64'h05556, 4};
        vecs[2]  = '{0, 32'h8000, 32'h8000, 1'b1, 64'h10001, 4};
        vecs[3]  = '{0, 32'h0000, 32'h0000, 1'b0, 64'h00000, 4};
        vecs[4]  = '{0, 32'hFFFF, 32'hFFFF, 1'b1, 64'h1FFFF, 4};
        vecs[5]  = '{0, 32'h0F0F, 32'h00F1, 1'b0, 64'h01000, 4};
        vecs[6]  = '{0, 32'hABCD, 32'h1111, 1'b0, 64'h0BCDE, 4};
        vecs[7]  = '{1, 32'hF,    32'h1,    1'b0, 64'h10,    1};
        vecs[8]  = '{1, 32'h7,    32'h8,    1'b1, 64'h10,    1};
        vecs[9]  = '{1, 32'h3,    32'h4,    1'b0, 64'h07,    1};
        vecs[10] = '{2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h100000000, 8};
        vecs[11] = '{2, 32'h12345678, 32'h87654321, 1'b0, 64'h099999999, 8};
        vecs[12] = '{2, 32'h80000000, 32'h80000000, 1'b1, 64'h100000001, 8};

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        #12;
        check("reset_sum16", {47'b0, cout[0], sum16}, 64'd0);
        check("reset_out_valid", {61'b0, out_valid}, 64'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", {61'b0, in_ready}, 64'h7);
        check("post_reset_out_valid", {61'b0, out_valid}, 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].c, 0, r, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Asynchronous reset mid-cycle while a nonzero result is held in IDLE
        run_op(0, 32'h1234, 32'h4321, 1'b1, 0, r, lat);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears_result", {46'b0, out_valid[0], cout[0], sum16}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after_async_reset_ready", {62'b0, in_ready[0], out_valid[0]}, 64'd2);

        // Backpressure in DONE with a competing in_valid
        op_a = 32'h1234;
        op_b = 32'h4321;
        cin  = 1'b1;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd4);
        held = got_res(0);
        check("bp_result", held, 64'h05556);
        op_a = 32'h0001;
        op_b = 32'h0001;
        cin  = 1'b0;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {60'b0, out_valid[0], in_ready[0], 2'b0} ^ got_res(0),
                  64'h8 ^ held);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("bp_release_idle", {62'b0, in_ready[0], out_valid[0]}, 64'd2);
        check("bp_result_kept_in_idle", got_res(0), held);

        // Reset on the second RUN cycle abandons the operation
        op_a = 32'hFFFF;
        op_b = 32'hFFFF;
        cin  = 1'b1;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid[0]) seen++;
        end
        check("abandoned_no_out_valid", 64'(seen), 64'd0);
        run_op(0, 32'h00FF, 32'h0001, 1'b0, 0, r, lat);
        check("first_op_after_reset", r, 64'h00100);

        // Random operands with random gaps on both sides
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a;
                logic [31:0] b;
                logic        c;
                a = $urandom;
                b = $urandom;
                c = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 2)) tick();
                run_op(d, a, b, c, $urandom_range(0, 3), r, lat);
                check($sformatf("rand_w%0d_result", width_of(d)), r, model(d, a, b, c));
                check($sformatf("rand_w%0d_latency", width_of(d)), 64'(lat),
                      64'(width_of(d) / 4));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
